spike_encoder_array: RTL and testbench
======================================

Name: spike_encoder_array

Overview:
Parametrised multi-channel successor of the single-channel periodic input neuron. It holds N_CH independent countdown timers, each with a runtime-programmable period. Each timer raises a sticky spike per channel that is held until the downstream synapse/arbiter acknowledges it. The block adds per-channel disable, phase restart and overrun (missed-spike) detection. It sits at the network input, converting ECG-feature rate codes into spike trains for the first neuron layer.

Parameters:
N_CH, 8, number of channels (>=1)
PERIOD_W, 4, period/counter width in bits
DEF_PERIOD, 4, period and counter value loaded into every channel at reset (0 = disabled)
MISS_CNT_W, 8, width of the global missed-spike counter (optional feature)

Ports:
clk  in  1  system clock, all state updates on posedge
resetn  in  1  asynchronous, active-low reset
timer_en  in  1  global tick enable; counters advance only when 1
restart  in  1  synchronous phase realign of all channels
period_wr  in  1  period write strobe
period_addr  in  AW  channel index for write; AW = max(1, ceil(log2(N_CH)))
period_data  in  PERIOD_W  new period value
ack_in  in  N_CH  per-channel spike acknowledge
clr_miss  in  1  clears all miss flags (and the counter when enabled)
spike  out  N_CH  per-channel sticky spike request
miss  out  N_CH  per-channel sticky overrun flag
miss_cnt  out  MISS_CNT_W  saturating overrun count (see Optional Feature)

Behaviour:
- Reset (resetn=0, async): P[i]=DEF_PERIOD, C[i]=DEF_PERIOD, spike=0, miss=0, miss_cnt=0.
- Per channel i, priority order each cycle (highest first):
  1. period_wr && period_addr==i: P[i]<=period_data, C[i]<=period_data; no fire this cycle.
  2. restart: C[i]<=P[i]; no fire.
  3. P[i]==0 (disabled): C[i] held at 0; never fires.
  4. timer_en && C[i]==1: fire; C[i]<=P[i].
  5. timer_en: C[i]<=C[i]-1.
  6. else: hold.
- Spike interval is exactly P[i] timer_en ticks. P=1 fires on every enabled tick. Max period is 2^PERIOD_W-1.
- period_addr >= N_CH: write ignored.
- Spike latency: spike[i] rises on the clock edge at which the fire occurs (registered output, visible the cycle after the firing tick is sampled).
- Spike handshake, per channel:
  - fire: spike<=1.
  - else if ack_in[i] && spike[i]: spike<=0.
  - ack_in while spike=0: ignored.
  - fire and ack in the same cycle: spike stays 1 (new event); not an overrun.
- Overrun: fire while spike[i]=1 and ack_in[i]=0 sets miss[i]=1; spike stays 1 (events merge).
- clr_miss clears all miss bits. If clr_miss and a new overrun occur on the same channel in the same cycle, set wins.
- restart and period_wr do not alter spike or miss.
- Reset asserted mid-operation: immediate return to reset values, including pending spikes.

Optional Feature:
- Macro SPIKE_ENC_MISS_CNT_EN.
- Defined:
  - miss_cnt increments by the number of channels overrunning that cycle, saturating at 2^MISS_CNT_W-1.
  - clr_miss zeroes it; if clr_miss and overruns coincide, the result equals that cycle's overrun count.
- Undefined: miss_cnt tied to 0; no counter logic is synthesised. The miss bits behave identically in both builds.

Test Plan:
- Reset with DEF_PERIOD=4, timer_en=1 constant, ack_in pulsed the cycle after each spike -> every channel spikes every 4 cycles, miss stays 0.
- Write ch2 period=1, ch5 period=0 -> ch2 spikes on every enabled tick; ch5 never spikes and C[5]=0.
- Hold ack_in[3]=0 across two fires on ch3 -> spike[3] stays 1 and miss[3]=1 after the second fire; with the macro, miss_cnt=1. Then clr_miss -> miss=0 and miss_cnt=0.
- ack_in[0] in the same cycle as ch0 fires -> spike[0] remains 1, miss[0]=0. Toggle timer_en 1/0 -> interval doubles in clock cycles and stays 4 ticks.
- period_wr to ch1 on its firing tick -> no spike, C[1]=new value. restart mid-count -> all counters realign to P, no spikes that cycle.
- Assert resetn=0 asynchronously between edges while spikes pending -> spike, miss and miss_cnt are 0 immediately. Run the macro build to saturation (MISS_CNT_W=2) -> miss_cnt holds at 3.

Source files
------------

// File: rtl/spike_encoder_array.sv
// -----------------------------------------------------------------------------
// spike_encoder_array
//
// This block converts rate codes into spike trains using N_CH independent
// countdown timers. Each timer has its own period, which can be changed at
// run time. When a timer expires it raises a sticky spike request. The request
// stays high until the downstream consumer acknowledges it. If a channel fires
// again before its previous spike was acknowledged, the block raises a sticky
// miss flag for that channel.
//
// Optional build macro: SPIKE_ENC_MISS_CNT_EN
//   Defined   : miss_cnt is a global saturating count of overruns.
//   Undefined : miss_cnt is tied to zero and no counter logic is built.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous reset, active low
//   timer_en     global tick enable; the counters advance only when it is high
//   restart      synchronous phase realign; every counter reloads its period
//   period_wr    period write strobe
//   period_addr  channel to write; indices >= N_CH are ignored
//   period_data  new period value (0 disables the channel)
//   ack_in       per-channel spike acknowledge
//   clr_miss     clears all miss flags, and the counter when it is built
//   spike        per-channel sticky spike request
//   miss         per-channel sticky overrun flag
//   miss_cnt     saturating overrun count (zero when the counter is not built)
// -----------------------------------------------------------------------------
module spike_encoder_array #(
  parameter  int N_CH       = 8,
  parameter  int PERIOD_W   = 4,
  parameter  int DEF_PERIOD = 4,
  parameter  int MISS_CNT_W = 8,
  localparam int AW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  timer_en,
  input  logic                  restart,
  input  logic                  period_wr,
  input  logic [AW-1:0]         period_addr,
  input  logic [PERIOD_W-1:0]   period_data,
  input  logic [N_CH-1:0]       ack_in,
  input  logic                  clr_miss,
  output logic [N_CH-1:0]       spike,
  output logic [N_CH-1:0]       miss,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEF_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

  logic [PERIOD_W-1:0] per_q [N_CH];
  logic [PERIOD_W-1:0] per_d [N_CH];
  logic [PERIOD_W-1:0] cnt_q [N_CH];
  logic [PERIOD_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]     spike_q, spike_d;
  logic [N_CH-1:0]     miss_q,  miss_d;
  logic [N_CH-1:0]     fire;
  logic [N_CH-1:0]     ovr;

  // Timer update. A period write or a restart always takes priority over a
  // fire, so a reload can never emit a spike in the same cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      per_d[i] = per_q[i];
      cnt_d[i] = cnt_q[i];
      fire[i]  = 1'b0;
      if (period_wr && (period_addr == AW'(i))) begin
        per_d[i] = period_data;
        cnt_d[i] = period_data;
      end else if (restart) begin
        cnt_d[i] = per_q[i];
      end else if (per_q[i] == '0) begin
        cnt_d[i] = '0;
      end else if (timer_en && (cnt_q[i] == ONE_P)) begin
        fire[i]  = 1'b1;
        cnt_d[i] = per_q[i];
      end else if (timer_en) begin
        cnt_d[i] = cnt_q[i] - ONE_P;
      end
    end
  end

  // Spike handshake. A fire always wins over an acknowledge, so an ack that
  // coincides with a new fire consumes the old event and leaves the new one
  // pending. An overrun is a fire onto a spike that is still unacknowledged.
  // An overrun beats clr_miss on the same channel.
  always_comb begin
    spike_d = fire | (spike_q & ~ack_in);
    ovr     = fire & spike_q & ~ack_in;
    miss_d  = ovr | (miss_q & {N_CH{~clr_miss}});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_CH; i++) begin
        per_q[i] <= DEF_P;
        cnt_q[i] <= DEF_P;
      end
      spike_q <= '0;
      miss_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        per_q[i] <= per_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      spike_q <= spike_d;
      miss_q  <= miss_d;
    end
  end

  assign spike = spike_q;
  assign miss  = miss_q;

`ifdef SPIKE_ENC_MISS_CNT_EN
  localparam int CW    = $clog2(N_CH + 1);
  localparam int SUM_W = ((MISS_CNT_W > CW) ? MISS_CNT_W : CW) + 1;
  localparam logic [MISS_CNT_W-1:0] CNT_MAX = {MISS_CNT_W{1'b1}};

  function automatic logic [CW-1:0] popcnt(input logic [N_CH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [MISS_CNT_W-1:0] sat_add(
    input logic [MISS_CNT_W-1:0] base,
    input logic [CW-1:0]         inc
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (sum > SUM_W'(CNT_MAX)) return CNT_MAX;
    return sum[MISS_CNT_W-1:0];
  endfunction

  logic [MISS_CNT_W-1:0] miss_cnt_q;
  logic [MISS_CNT_W-1:0] miss_cnt_d;

  // A clear zeroes the base before the count is added. When a clear and an
  // overrun happen in the same cycle, the result is that cycle's overruns.
  always_comb begin
    miss_cnt_d = sat_add(clr_miss ? '0 : miss_cnt_q, popcnt(ovr));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) miss_cnt_q <= '0;
    else         miss_cnt_q <= miss_cnt_d;
  end

  assign miss_cnt = miss_cnt_q;
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_encoder_array.sv
// -----------------------------------------------------------------------------
// tb_spike_encoder_array
//
// Testbench for spike_encoder_array. It runs directed scenarios and then
// randomized traffic. Every cycle it compares spike, miss and miss_cnt against
// a phase-accumulator reference model. The model counts enabled ticks since
// the last reload and fires when that count reaches the period.
// -----------------------------------------------------------------------------
module tb_spike_encoder_array;

  localparam int N_CH   = 6;
  localparam int PW     = 4;
  localparam int DEFP   = 4;
  localparam int MCW    = 2;
  localparam int AW     = 3;
  localparam int MC_MAX = (1 << MCW) - 1;

  logic            clk = 1'b0;
  logic            resetn;
  logic            timer_en, restart, period_wr, clr_miss;
  logic [AW-1:0]   period_addr;
  logic [PW-1:0]   period_data;
  logic [N_CH-1:0] ack_in;
  logic [N_CH-1:0] spike, miss;
  logic [MCW-1:0]  miss_cnt;

  spike_encoder_array #(
    .N_CH(N_CH), .PERIOD_W(PW), .DEF_PERIOD(DEFP), .MISS_CNT_W(MCW)
  ) dut (
    .clk(clk), .resetn(resetn), .timer_en(timer_en), .restart(restart),
    .period_wr(period_wr), .period_addr(period_addr), .period_data(period_data),
    .ack_in(ack_in), .clr_miss(clr_miss), .spike(spike), .miss(miss),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_per [N_CH];
  int m_ph  [N_CH];
  bit m_sp  [N_CH];
  bit m_ms  [N_CH];
  int m_mc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_per[i] = DEFP;
      m_ph[i]  = 0;
      m_sp[i]  = 1'b0;
      m_ms[i]  = 1'b0;
    end
    m_mc = 0;
  endtask

  function automatic logic [N_CH-1:0] model_spikes();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_sp[i];
    return v;
  endfunction

  task automatic model_step(input logic te, input logic rs, input logic wr, input int addr,
                            input int data, input logic [N_CH-1:0] ack, input logic clr);
    int n_ovr;
    n_ovr = 0;
    for (int i = 0; i < N_CH; i++) begin
      bit f, ov;
      f  = 1'b0;
      ov = 1'b0;
      if (wr && addr == i) begin
        m_per[i] = data;
        m_ph[i]  = 0;
      end else if (rs || m_per[i] == 0) begin
        m_ph[i] = 0;
      end else if (te) begin
        if (m_ph[i] + 1 == m_per[i]) begin
          f       = 1'b1;
          m_ph[i] = 0;
        end else begin
          m_ph[i]++;
        end
      end
      if (f) begin
        if (m_sp[i] && !ack[i]) begin
          ov = 1'b1;
          n_ovr++;
        end
        m_sp[i] = 1'b1;
      end else if (ack[i]) begin
        m_sp[i] = 1'b0;
      end
      if (ov)       m_ms[i] = 1'b1;
      else if (clr) m_ms[i] = 1'b0;
    end
    m_mc = (clr ? 0 : m_mc) + n_ovr;
    if (m_mc > MC_MAX) m_mc = MC_MAX;
  endtask

  task automatic check_outs(input string tag);
    logic [N_CH-1:0] e_sp, e_ms;
    int e_mc;
    for (int i = 0; i < N_CH; i++) begin
      e_sp[i] = m_sp[i];
      e_ms[i] = m_ms[i];
    end
`ifdef SPIKE_ENC_MISS_CNT_EN
    e_mc = m_mc;
`else
    e_mc = 0;
`endif
    chk({tag, ".spike"},    32'(spike),    32'(e_sp));
    chk({tag, ".miss"},     32'(miss),     32'(e_ms));
    chk({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(e_mc));
  endtask

  // Inputs are driven at the falling edge, sampled by the DUT on the rising
  // edge, and the outputs are checked at the next falling edge.
  task automatic cyc(input string tag, input logic te, input logic rs, input logic wr,
                     input int addr, input int data, input logic [N_CH-1:0] ack,
                     input logic clr);
    timer_en    = te;
    restart     = rs;
    period_wr   = wr;
    period_addr = AW'(addr);
    period_data = PW'(data);
    ack_in      = ack;
    clr_miss    = clr;
    model_step(te, rs, wr, addr, data, ack, clr);
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic async_reset_check(input string tag);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk({tag, ".spike0"}, 32'(spike),    32'd0);
    chk({tag, ".miss0"},  32'(miss),     32'd0);
    chk({tag, ".cnt0"},   32'(miss_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    check_outs(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    resetn = 1'b0;
    timer_en = 1'b0; restart = 1'b0; period_wr = 1'b0; clr_miss = 1'b0;
    period_addr = '0; period_data = '0; ack_in = '0;
    model_reset();
    #12;
    chk("reset.spike",    32'(spike),    32'd0);
    chk("reset.miss",     32'(miss),     32'd0);
    chk("reset.miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    check_outs("release");

    // Default period on every channel, with an ack the cycle after each spike
    repeat (20) cyc("default", 1, 0, 0, 0, 0, model_spikes(), 0);

    // ch2 fires every tick, ch5 is disabled
    cyc("wr_ch2", 1, 0, 1, 2, 1, model_spikes(), 0);
    cyc("wr_ch5", 1, 0, 1, 5, 0, model_spikes(), 0);
    repeat (12) cyc("p1_p0", 1, 0, 0, 0, 0, model_spikes(), 0);

    // Withhold the ack on ch3 across two fires, then clear
    repeat (10) cyc("hold3", 1, 0, 0, 0, 0, model_spikes() & 6'b110111, 0);
    cyc("clr", 1, 0, 0, 0, 0, model_spikes(), 1);
    repeat (4) cyc("post_clr", 1, 0, 0, 0, 0, model_spikes(), 0);

    // ch0 is acked every cycle, including its fire cycle; timer_en toggles
    for (int k = 0; k < 24; k++)
      cyc("ack0_toggle", (k % 2) == 0, 0, 0, 0, 0, model_spikes() | 6'b000001, 0);

    // Period write to ch1 on the tick where ch1 would fire
    guard = 0;
    while (!(m_ph[1] + 1 == m_per[1]) && guard < 20) begin
      cyc("seek1", 1, 0, 0, 0, 0, model_spikes(), 0);
      guard++;
    end
    chk("seek1.found", 32'(guard < 20), 32'd1);
    cyc("wr_on_fire", 1, 0, 1, 1, 7, model_spikes(), 0);
    repeat (3) cyc("after_wr", 1, 0, 0, 0, 0, model_spikes(), 0);
    cyc("restart", 1, 1, 0, 0, 0, model_spikes(), 0);
    cyc("wr_bad6", 1, 0, 1, 6, 1, model_spikes(), 0);
    cyc("wr_bad7", 1, 0, 1, 7, 2, model_spikes(), 0);
    repeat (16) cyc("after_rs", 1, 0, 0, 0, 0, model_spikes(), 0);

    // Build pending spikes and misses, then reset asynchronously
    cyc("wr_ch0", 1, 0, 1, 0, 2, 6'b0, 0);
    repeat (8) cyc("pend", 1, 0, 0, 0, 0, 6'b0, 0);
    async_reset_check("areset1");

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc("rand",
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0,
          $urandom_range(0, 12) == 0,
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, 15)),
          N_CH'($urandom & $urandom),
          $urandom_range(0, 25) == 0);
      if (k == 1500) async_reset_check("areset2");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
